// File: rtl/proc_dmem_mmio.sv
// Data-memory MMIO front end for the datapath M stage.
// Forwards non-MMIO accesses to data memory. Inside the 16-byte window it serves
// an output FIFO, a status register, a cycle counter and a control register.
// All read data is combinational in the request cycle.
module proc_dmem_mmio #(
  parameter int unsigned p_depth     = 4,
  parameter logic [31:0] p_mmio_base = 32'h0000_F000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmemreq_val,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic [31:0] dmemresp_rdata,
  output logic        memreq_val,
  output logic        memreq_type,
  output logic [31:0] memreq_addr,
  output logic [31:0] memreq_wdata,
  input  logic [31:0] memresp_rdata,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [31:0] out_data
);

  localparam int unsigned PtrW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int unsigned CntW = $clog2(p_depth + 1);

  localparam logic [1:0] RegOut    = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;
  localparam logic [1:0] RegCycle  = 2'd2;
  localparam logic [1:0] RegCtrl   = 2'd3;

  logic [31:0]     mem_q [p_depth];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     cycle_q, cycle_d;

  logic       hit;
  logic [1:0] reg_sel;
  logic       mmio_st;
  logic       push, push_acc, pop, flush, clr_ovf, cyc_wr;
  logic [7:0] count8;
  logic       unused_addr;

  // Byte offset within a word is meaningless for these word registers.
  assign unused_addr = ^dmemreq_addr[1:0];

  // Request decode.
  assign hit     = dmemreq_addr[31:4] == p_mmio_base[31:4];
  assign reg_sel = dmemreq_addr[3:2];
  assign mmio_st = dmemreq_val && hit && dmemreq_type;

  assign push    = mmio_st && (reg_sel == RegOut);
  assign flush   = mmio_st && (reg_sel == RegCtrl) && dmemreq_wdata[0];
  assign clr_ovf = mmio_st && (reg_sel == RegCtrl) && dmemreq_wdata[1];
  assign cyc_wr  = mmio_st && (reg_sel == RegCycle);
  // Flush wins over a simultaneous pop.
  assign pop      = out_val && out_rdy && !flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_acc = push && ((count_q < CntW'(p_depth)) || pop);

  // Pass-through to data memory.
  assign memreq_val   = dmemreq_val && !hit;
  assign memreq_type  = dmemreq_type;
  assign memreq_addr  = dmemreq_addr;
  assign memreq_wdata = dmemreq_wdata;

  assign out_val  = (count_q != '0);
  assign out_data = mem_q[head_q];
  assign count8   = 8'(count_q);

  // Load data mux: memory, MMIO register, or zero when idle.
  always_comb begin
    dmemresp_rdata = 32'h0;
    if (dmemreq_val) begin
      if (!hit) begin
        dmemresp_rdata = memresp_rdata;
      end else begin
        unique case (reg_sel)
          RegStatus: dmemresp_rdata = {ovf_q, 23'b0, count8};
          RegCycle:  dmemresp_rdata = cycle_q;
          default:   dmemresp_rdata = 32'h0;
        endcase
      end
    end
  end

  // FIFO pointer/occupancy/overflow and cycle counter next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    cycle_d = cyc_wr ? dmemreq_wdata : cycle_q + 32'd1;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)      head_d = head_q + PtrW'(1);
      if (push_acc) tail_d = tail_q + PtrW'(1);
      if (push_acc && !pop)      count_d = count_q + CntW'(1);
      else if (!push_acc && pop) count_d = count_q - CntW'(1);
    end
    if (push && !push_acc) ovf_d = 1'b1;
    if (clr_ovf)           ovf_d = 1'b0;
  end

  // State registers; reset clears everything including FIFO storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      cycle_q <= 32'h0;
      for (int i = 0; i < int'(p_depth); i++) mem_q[i] <= 32'h0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      cycle_q <= cycle_d;
      if (push_acc) mem_q[tail_q] <= dmemreq_wdata;
    end
  end

endmodule

// File: tb/tb_proc_dmem_mmio.sv
// Directed self-checking bench for proc_dmem_mmio (p_depth = 4).
module tb_proc_dmem_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmemreq_val, dmemreq_type;
  logic [31:0] dmemreq_addr, dmemreq_wdata;
  logic [31:0] dmemresp_rdata;
  logic        memreq_val, memreq_type;
  logic [31:0] memreq_addr, memreq_wdata;
  logic [31:0] memresp_rdata;
  logic        out_val, out_rdy;
  logic [31:0] out_data;

  int errs = 0;
  int checks = 0;

  proc_dmem_mmio #(.p_depth(4), .p_mmio_base(32'h0000_F000)) dut (
    .clk(clk), .rst(rst),
    .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type),
    .dmemreq_addr(dmemreq_addr), .dmemreq_wdata(dmemreq_wdata),
    .dmemresp_rdata(dmemresp_rdata),
    .memreq_val(memreq_val), .memreq_type(memreq_type),
    .memreq_addr(memreq_addr), .memreq_wdata(memreq_wdata),
    .memresp_rdata(memresp_rdata),
    .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic t, input logic [31:0] a, input logic [31:0] d);
    dmemreq_val   = v;
    dmemreq_type  = t;
    dmemreq_addr  = a;
    dmemreq_wdata = d;
  endtask

  task automatic idle();
    req(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    idle();
    out_rdy = 1'b0;
    memresp_rdata = 32'h0;
    rst = 1'b1;
    #1;
    req(1'b1, 1'b0, 32'h0000_0200, 32'h0);
    #1;
    checks++;
    if (memreq_val !== 1'b1) begin
      errs++; $display("FAIL reset_memreq_val got=%0b exp=1", memreq_val);
    end
    checks++;
    if (out_val !== 1'b0 || out_data !== 32'h0) begin
      errs++; $display("FAIL reset_out got val=%0b data=%h exp 0/0", out_val, out_data);
    end
    idle();
    tick();
    tick();
    rst = 1'b0;
    // five idle edges
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (out_val !== 1'b0) begin
      errs++; $display("FAIL idle_out_val got=%0b exp=0", out_val);
    end
    req(1'b1, 1'b0, 32'h0000_F008, 32'h0);
    #1;
    checks++;
    if (dmemresp_rdata !== 32'd5) begin
      errs++; $display("FAIL cycle_after_5 got=%h exp=%h", dmemresp_rdata, 32'd5);
    end
  endtask

  task automatic test_cycle_wrap();
    req(1'b1, 1'b1, 32'h0000_F008, 32'hFFFF_FFFF);
    tick();
    req(1'b1, 1'b0, 32'h0000_F008, 32'h0);
    #1;
    checks++;
    if (dmemresp_rdata !== 32'hFFFF_FFFF) begin
      errs++; $display("FAIL cycle_loaded got=%h exp=ffffffff", dmemresp_rdata);
    end
    tick();
    checks++;
    if (dmemresp_rdata !== 32'h0) begin
      errs++; $display("FAIL cycle_wrap got=%h exp=00000000", dmemresp_rdata);
    end
    idle();
  endtask

  task automatic test_fifo_basic();
    logic [31:0] exp [3];
    exp[0] = 32'hA; exp[1] = 32'hB; exp[2] = 32'hC;
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(1'b1, 1'b1, 32'h0000_F000, exp[i]);
      tick();
    end
    req(1'b1, 1'b0, 32'h0000_F004, 32'h0);
    #1;
    checks++;
    if (dmemresp_rdata !== 32'h0000_0003) begin
      errs++; $display("FAIL status_3 got=%h exp=00000003", dmemresp_rdata);
    end
    checks++;
    if (out_val !== 1'b1 || out_data !== 32'hA) begin
      errs++; $display("FAIL head_A got val=%0b data=%h exp 1/0000000a", out_val, out_data);
    end
    req(1'b1, 1'b0, 32'h0000_F000, 32'h0);
    #1;
    checks++;
    if (dmemresp_rdata !== 32'h0) begin
      errs++; $display("FAIL outdata_load got=%h exp=00000000", dmemresp_rdata);
    end
    idle();
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_val !== 1'b1 || out_data !== exp[i]) begin
        errs++; $display("FAIL drain_%0d got val=%0b data=%h exp 1/%h", i, out_val, out_data, exp[i]);
      end
      tick();
    end
    checks++;
    if (out_val !== 1'b0) begin
      errs++; $display("FAIL drain_empty got=%0b exp=0", out_val);
    end
    out_rdy = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] exp [4];
    exp[0] = 32'h2; exp[1] = 32'h3; exp[2] = 32'h4; exp[3] = 32'hF;
    out_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      req(1'b1, 1'b1, 32'h0000_F000, 32'(i));
      tick();
    end
    req(1'b1, 1'b1, 32'h0000_F000, 32'hE);
    tick();
    req(1'b1, 1'b0, 32'h0000_F004, 32'h0);
    #1;
    checks++;
    if (dmemresp_rdata !== 32'h8000_0004) begin
      errs++; $display("FAIL ovf_status got=%h exp=80000004", dmemresp_rdata);
    end
    checks++;
    if (out_data !== 32'h1) begin
      errs++; $display("FAIL ovf_head got=%h exp=00000001", out_data);
    end
    req(1'b1, 1'b1, 32'h0000_F000, 32'hF);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    req(1'b1, 1'b0, 32'h0000_F004, 32'h0);
    #1;
    checks++;
    if (dmemresp_rdata !== 32'h8000_0004) begin
      errs++; $display("FAIL full_pushpop_status got=%h exp=80000004", dmemresp_rdata);
    end
    req(1'b1, 1'b1, 32'h0000_F00C, 32'h2);
    tick();
    req(1'b1, 1'b0, 32'h0000_F004, 32'h0);
    #1;
    checks++;
    if (dmemresp_rdata !== 32'h0000_0004) begin
      errs++; $display("FAIL ovf_clear got=%h exp=00000004", dmemresp_rdata);
    end
    idle();
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_val !== 1'b1 || out_data !== exp[i]) begin
        errs++; $display("FAIL ovf_drain_%0d got val=%0b data=%h exp 1/%h", i, out_val, out_data, exp[i]);
      end
      tick();
    end
    out_rdy = 1'b0;
  endtask

  task automatic test_flush();
    out_rdy = 1'b0;
    req(1'b1, 1'b1, 32'h0000_F000, 32'h11);
    tick();
    req(1'b1, 1'b1, 32'h0000_F000, 32'h22);
    tick();
    out_rdy = 1'b1;
    req(1'b1, 1'b1, 32'h0000_F00C, 32'h1);
    tick();
    out_rdy = 1'b0;
    req(1'b1, 1'b0, 32'h0000_F004, 32'h0);
    #1;
    checks++;
    if (out_val !== 1'b0 || dmemresp_rdata !== 32'h0) begin
      errs++; $display("FAIL flush got val=%0b status=%h exp 0/00000000", out_val, dmemresp_rdata);
    end
    // pointers must be back at 0: push then read the head
    req(1'b1, 1'b1, 32'h0000_F000, 32'h33);
    tick();
    idle();
    #1;
    checks++;
    if (out_val !== 1'b1 || out_data !== 32'h33) begin
      errs++; $display("FAIL flush_repush got val=%0b data=%h exp 1/00000033", out_val, out_data);
    end
    req(1'b1, 1'b1, 32'h0000_F00C, 32'h1);
    tick();
    idle();
  endtask

  task automatic test_passthrough();
    memresp_rdata = 32'h1234_5678;
    req(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    #1;
    checks++;
    if (memreq_val !== 1'b1 || dmemresp_rdata !== 32'h1234_5678 || memreq_addr !== 32'h100) begin
      errs++; $display("FAIL pass_load got val=%0b rdata=%h addr=%h exp 1/12345678/00000100",
                       memreq_val, dmemresp_rdata, memreq_addr);
    end
    req(1'b1, 1'b1, 32'h0000_0104, 32'hCAFE_F00D);
    #1;
    checks++;
    if (memreq_type !== 1'b1 || memreq_wdata !== 32'hCAFE_F00D || dmemresp_rdata !== 32'h1234_5678) begin
      errs++; $display("FAIL pass_store got type=%0b wdata=%h rdata=%h exp 1/cafef00d/12345678",
                       memreq_type, memreq_wdata, dmemresp_rdata);
    end
    idle();
    #1;
    checks++;
    if (dmemresp_rdata !== 32'h0 || memreq_val !== 1'b0) begin
      errs++; $display("FAIL idle_rdata got rdata=%h val=%0b exp 0/0", dmemresp_rdata, memreq_val);
    end
    req(1'b1, 1'b1, 32'h0000_F004, 32'hFFFF_FFFF);
    #1;
    checks++;
    if (memreq_val !== 1'b0) begin
      errs++; $display("FAIL mmio_no_fwd got=%0b exp=0", memreq_val);
    end
    tick();
    req(1'b1, 1'b0, 32'h0000_F004, 32'h0);
    #1;
    checks++;
    if (dmemresp_rdata !== 32'h0) begin
      errs++; $display("FAIL status_store_ignored got=%h exp=00000000", dmemresp_rdata);
    end
    idle();
    memresp_rdata = 32'h0;
  endtask

  task automatic test_reset_mid_drain();
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(1'b1, 1'b1, 32'h0000_F000, 32'h40 + 32'(i));
      tick();
    end
    idle();
    out_rdy = 1'b1;
    tick();
    checks++;
    if (out_val !== 1'b1 || out_data !== 32'h41) begin
      errs++; $display("FAIL pre_reset got val=%0b data=%h exp 1/00000041", out_val, out_data);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_val !== 1'b0 || out_data !== 32'h0) begin
      errs++; $display("FAIL async_reset got val=%0b data=%h exp 0/00000000", out_val, out_data);
    end
    tick();
    rst = 1'b0;
    out_rdy = 1'b0;
    tick();
    req(1'b1, 1'b0, 32'h0000_F004, 32'h0);
    #1;
    checks++;
    if (dmemresp_rdata !== 32'h0 || out_val !== 1'b0) begin
      errs++; $display("FAIL post_reset got status=%h val=%0b exp 00000000/0", dmemresp_rdata, out_val);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_cycle_wrap();
    test_fifo_basic();
    test_overflow();
    test_flush();
    test_passthrough();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
